// File: rtl/obstacle_spawner_pkg.sv
// Shared screen geometry, coordinate widths and the spawn-x mapping used
// by the obstacle spawner and its slot sub-module.
package obstacle_spawner_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int OBJ_W_DEF    = 32;
  localparam int OBJ_H_DEF    = 16;
  localparam int COORD_W      = 10;
  localparam int ARITH_W      = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ARITH_W-1:0] wide_t;

  // Fold an RNG sample into [0, xr); relies on 2*xr exceeding the RNG range.
  function automatic coord_t map_spawn_x(input coord_t rnd, input coord_t xr);
    coord_t res;
    if (rnd < xr) begin
      res = rnd;
    end else begin
      res = coord_t'(rnd - xr);
    end
    return res;
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Game-side and pixel-side signal bundle of the obstacle spawner.
import obstacle_spawner_pkg::*;

interface obstacle_spawner_if #(
  parameter int NUM_OBJ = 4
);
  logic               enable;
  logic               frame;
  coord_t             rand_i;
  coord_t             pix_x;
  coord_t             pix_y;
  logic               hit_o;
  logic               spawn_o;
  logic [NUM_OBJ-1:0] obj_active_o;
  logic [7:0]         drop_cnt_o;

  modport master (
    output enable, frame, rand_i, pix_x, pix_y,
    input  hit_o, spawn_o, obj_active_o, drop_cnt_o
  );

  modport slave (
    input  enable, frame, rand_i, pix_x, pix_y,
    output hit_o, spawn_o, obj_active_o, drop_cnt_o
  );
endinterface

// File: rtl/obstacle_spawner_slot.sv
// One falling obstacle: position/active state, per-frame motion with
// off-screen drop, spawn load and the pixel-inside test.
import obstacle_spawner_pkg::*;

module obstacle_slot #(
  parameter int OBJ_W    = OBJ_W_DEF,
  parameter int OBJ_H    = OBJ_H_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPEED    = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   move,
  input  logic   load,
  input  coord_t load_x,
  input  coord_t pix_x,
  input  coord_t pix_y,
  output logic   active,
  output logic   drop,
  output logic   hit
);

  logic   active_r;
  coord_t x_r;
  coord_t y_r;
  wide_t  y_next_s;
  logic   in_x_s;
  logic   in_y_s;

  // Next row and the off-screen test, done one bit wider than a coordinate
  always_comb begin
    y_next_s = wide_t'(y_r) + wide_t'(SPEED);
    drop     = active_r & move & (y_next_s >= wide_t'(SCREEN_H));
  end

  // Pixel-inside test against the current (pre-update) position
  always_comb begin
    in_x_s = (wide_t'(pix_x) >= wide_t'(x_r)) &&
             (wide_t'(pix_x) <  (wide_t'(x_r) + wide_t'(OBJ_W)));
    in_y_s = (wide_t'(pix_y) >= wide_t'(y_r)) &&
             (wide_t'(pix_y) <  (wide_t'(y_r) + wide_t'(OBJ_H)));
    hit    = active_r & in_x_s & in_y_s;
  end

  // Slot state: load only ever targets an inactive slot, so it never meets a move
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= 1'b0;
      x_r      <= {COORD_W{1'b0}};
      y_r      <= {COORD_W{1'b0}};
    end else if (load) begin
      active_r <= 1'b1;
      x_r      <= load_x;
      y_r      <= {COORD_W{1'b0}};
    end else if (drop) begin
      active_r <= 1'b0;
      x_r      <= {COORD_W{1'b0}};
      y_r      <= {COORD_W{1'b0}};
    end else if (active_r && move) begin
      y_r      <= y_next_s[COORD_W-1:0];
    end else begin
      y_r      <= y_r;
    end
  end

  assign active = active_r;

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle pool: frame-edge detection, periodic spawn into the lowest free
// slot at an RNG-derived column, drop counting and the registered pixel hit.
import obstacle_spawner_pkg::*;

module obstacle_spawner #(
  parameter int NUM_OBJ      = 4,
  parameter int OBJ_W        = OBJ_W_DEF,
  parameter int OBJ_H        = OBJ_H_DEF,
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int SPAWN_PERIOD = 30,
  parameter int SPEED        = 2
) (
  input  logic                clk,
  input  logic                rst,
  obstacle_spawner_if.slave   bus
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  logic               frame_d_r;
  logic [CNT_W-1:0]   spawn_cnt_r;
  logic [7:0]         drop_cnt_r;
  logic               hit_r;
  logic               spawn_r;

  logic               frame_tick_s;
  logic               update_s;
  logic               attempt_s;
  logic               free_found_s;
  logic [NUM_OBJ-1:0] free_onehot_s;
  logic [NUM_OBJ-1:0] load_s;
  logic [NUM_OBJ-1:0] active_s;
  logic [NUM_OBJ-1:0] drop_s;
  logic [NUM_OBJ-1:0] hit_s;
  logic [8:0]         drop_sum_s;
  logic [8:0]         drop_total_s;
  coord_t             spawn_x_s;

  // Rising-edge frame update gated by the game-running flag
  always_comb begin
    frame_tick_s = bus.frame & ~frame_d_r;
    update_s     = frame_tick_s & bus.enable;
    attempt_s    = update_s & (spawn_cnt_r == CNT_W'(SPAWN_PERIOD - 1));
    spawn_x_s    = map_spawn_x(bus.rand_i, coord_t'(SCREEN_W - OBJ_W));
  end

  // Lowest-index slot that is inactive before this update
  always_comb begin
    free_found_s  = 1'b0;
    free_onehot_s = {NUM_OBJ{1'b0}};
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!active_s[i] && !free_found_s) begin
        free_found_s     = 1'b1;
        free_onehot_s[i] = 1'b1;
      end else begin
        free_onehot_s[i] = 1'b0;
      end
    end
    load_s = attempt_s ? free_onehot_s : {NUM_OBJ{1'b0}};
  end

  // Number of slots leaving the screen this cycle, added to the running count
  always_comb begin
    drop_sum_s = 9'd0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      drop_sum_s = drop_sum_s + {8'd0, drop_s[i]};
    end
    drop_total_s = {1'b0, drop_cnt_r} + drop_sum_s;
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
    obstacle_slot #(
      .OBJ_W    (OBJ_W),
      .OBJ_H    (OBJ_H),
      .SCREEN_H (SCREEN_H),
      .SPEED    (SPEED)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .move   (update_s),
      .load   (load_s[g]),
      .load_x (spawn_x_s),
      .pix_x  (bus.pix_x),
      .pix_y  (bus.pix_y),
      .active (active_s[g]),
      .drop   (drop_s[g]),
      .hit    (hit_s[g])
    );
  end

  // Control registers; reset wins over any concurrent frame update
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_d_r   <= 1'b0;
      spawn_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r  <= 8'd0;
      hit_r       <= 1'b0;
      spawn_r     <= 1'b0;
    end else begin
      frame_d_r <= bus.frame;
      hit_r     <= |hit_s;
      spawn_r   <= attempt_s & free_found_s;
      if (attempt_s) begin
        spawn_cnt_r <= {CNT_W{1'b0}};
      end else if (update_s) begin
        spawn_cnt_r <= spawn_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        spawn_cnt_r <= spawn_cnt_r;
      end
      if (drop_total_s > 9'd255) begin
        drop_cnt_r <= 8'd255;
      end else begin
        drop_cnt_r <= drop_total_s[7:0];
      end
    end
  end

  assign bus.hit_o        = hit_r;
  assign bus.spawn_o      = spawn_r;
  assign bus.obj_active_o = active_s;
  assign bus.drop_cnt_o   = drop_cnt_r;

endmodule
